// File: rtl/piece_blitter_pkg.sv
// Shared types and constants for the sequential piece blitter.
//   blit_mode_t     : what FINISH publishes on out_screen
//   blit_state_t    : scan controller states
//   BLIT_WIN        : default piece window edge
//   BLIT_ORIGIN_OFS : default offset from (px,py) to the window's (0,0) cell
package piece_blitter_pkg;

   typedef enum logic [1:0] {
      BlitOverlay = 2'd0,
      BlitCheck   = 2'd1,
      BlitCommit  = 2'd2,
      BlitRsvd    = 2'd3   // behaves as BlitCheck
   } blit_mode_t;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StFinish
   } blit_state_t;

   localparam int unsigned BLIT_WIN        = 4;
   localparam int unsigned BLIT_ORIGIN_OFS = 4;

endpackage

// File: rtl/piece_blitter_row_unit.sv
// blit_row_unit: combinational processing of one piece-window row.
// Ports:
//   dy        : window row index being processed
//   row_cells : the row's WIN cells, indexed by dx (already gated by no_piece)
//   px, py    : window position
//   work_in   : current working board [x][y]
//   base_in   : untouched base copy [x][y]
//   work_out  : working board with this row's in-bounds cells set
//   row_coll  : some cell of this row hit a filled base cell
//   row_oob   : some cell of this row fell outside the board
module blit_row_unit #(
   parameter int unsigned BOARD_W    = 10,
   parameter int unsigned BOARD_H    = 20,
   parameter int unsigned WIN        = 4,
   parameter int unsigned ORIGIN_OFS = 4,
   parameter int unsigned CW         = 5,
   parameter int unsigned DYW        = 2
) (
   input  logic [DYW-1:0]                  dy,
   input  logic [WIN-1:0]                  row_cells,
   input  logic [CW-1:0]                   px,
   input  logic [CW-1:0]                   py,
   input  logic [BOARD_W-1:0][BOARD_H-1:0] work_in,
   input  logic [BOARD_W-1:0][BOARD_H-1:0] base_in,
   output logic [BOARD_W-1:0][BOARD_H-1:0] work_out,
   output logic                            row_coll,
   output logic                            row_oob
);

   localparam int unsigned XW = $clog2(BOARD_W);
   localparam int unsigned YW = $clog2(BOARD_H);
   localparam logic signed [CW+1:0] XLIM = (CW+2)'(BOARD_W);
   localparam logic signed [CW+1:0] YLIM = (CW+2)'(BOARD_H);
   localparam logic signed [CW+1:0] OFS  = (CW+2)'(ORIGIN_OFS);

   logic signed [CW+1:0] bx;
   logic signed [CW+1:0] by;
   logic [XW-1:0]        xi;
   logic [YW-1:0]        yi;

   always_comb begin
      work_out = work_in;
      row_coll = 1'b0;
      row_oob  = 1'b0;
      bx       = '0;
      xi       = '0;
      // Two extra bits keep px+dx-ofs exact and let negatives show up as sign.
      by       = signed'({2'b00, py}) + signed'((CW+2)'(dy)) - OFS;
      yi       = by[YW-1:0];
      for (int dx = 0; dx < int'(WIN); dx++) begin
         bx = signed'({2'b00, px}) + signed'((CW+2)'(dx)) - OFS;
         xi = bx[XW-1:0];
         if (row_cells[dx]) begin
            if (bx < 0 || bx >= XLIM || by < 0 || by >= YLIM) begin
               row_oob = 1'b1;
            end else begin
               if (base_in[xi][yi]) row_coll = 1'b1;
               work_out[xi][yi] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/piece_blitter.sv
// piece_blitter: captures a board and a piece window on start, scans the window
// one row per cycle, then publishes the composed board and collision/oob flags.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start           : job request, accepted only when idle
//   mode            : OVERLAY / CHECK / COMMIT (3 behaves as CHECK)
//   no_piece        : suppress all piece cells
//   base_screen     : board [x][y], 1 = filled
//   piece           : window [dx][dy], 1 = filled
//   px, py          : window position
//   out_screen      : published board, held until the next finish
//   busy            : job in progress (scan and finish cycles)
//   done            : one-cycle pulse, outputs valid
//   collision, oob  : result flags, held until the next finish
module piece_blitter
   import piece_blitter_pkg::*;
#(
   parameter int unsigned BOARD_W    = 10,
   parameter int unsigned BOARD_H    = 20,
   parameter int unsigned WIN        = BLIT_WIN,
   parameter int unsigned ORIGIN_OFS = BLIT_ORIGIN_OFS,
   parameter int unsigned CW         = 5
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  blit_mode_t                      mode,
   input  logic                            no_piece,
   input  logic [BOARD_W-1:0][BOARD_H-1:0] base_screen,
   input  logic [WIN-1:0][WIN-1:0]         piece,
   input  logic [CW-1:0]                   px,
   input  logic [CW-1:0]                   py,
   output logic [BOARD_W-1:0][BOARD_H-1:0] out_screen,
   output logic                            busy,
   output logic                            done,
   output logic                            collision,
   output logic                            oob
);

   localparam int unsigned DYW = (WIN > 1) ? $clog2(WIN) : 1;

   blit_state_t                     state_q, state_d;
   blit_mode_t                      mode_q, mode_d;
   logic                            np_q, np_d;
   logic [WIN-1:0][WIN-1:0]         piece_q, piece_d;
   logic [CW-1:0]                   px_q, px_d, py_q, py_d;
   logic [DYW-1:0]                  dy_q, dy_d;
   logic [BOARD_W-1:0][BOARD_H-1:0] work_q, work_d, base_q, base_d;
   logic [BOARD_W-1:0][BOARD_H-1:0] out_q, out_d;
   logic                            coll_acc_q, coll_acc_d, oob_acc_q, oob_acc_d;
   logic                            coll_q, coll_d, oob_q, oob_d;

   logic [WIN-1:0]                  row_cells;
   logic [BOARD_W-1:0][BOARD_H-1:0] row_work;
   logic                            row_coll, row_oob;

   always_comb begin
      row_cells = '0;
      for (int dx = 0; dx < int'(WIN); dx++) begin
         row_cells[dx] = piece_q[dx][dy_q] & ~np_q;
      end
   end

   blit_row_unit #(
      .BOARD_W    (BOARD_W),
      .BOARD_H    (BOARD_H),
      .WIN        (WIN),
      .ORIGIN_OFS (ORIGIN_OFS),
      .CW         (CW),
      .DYW        (DYW)
   ) u_row (
      .dy        (dy_q),
      .row_cells (row_cells),
      .px        (px_q),
      .py        (py_q),
      .work_in   (work_q),
      .base_in   (base_q),
      .work_out  (row_work),
      .row_coll  (row_coll),
      .row_oob   (row_oob)
   );

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      np_d       = np_q;
      piece_d    = piece_q;
      px_d       = px_q;
      py_d       = py_q;
      dy_d       = dy_q;
      work_d     = work_q;
      base_d     = base_q;
      out_d      = out_q;
      coll_acc_d = coll_acc_q;
      oob_acc_d  = oob_acc_q;
      coll_d     = coll_q;
      oob_d      = oob_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StScan;
               mode_d     = mode;
               np_d       = no_piece;
               piece_d    = piece;
               px_d       = px;
               py_d       = py;
               work_d     = base_screen;
               base_d     = base_screen;
               coll_acc_d = 1'b0;
               oob_acc_d  = 1'b0;
               dy_d       = '0;
            end
         end
         StScan: begin
            work_d     = row_work;
            coll_acc_d = coll_acc_q | row_coll;
            oob_acc_d  = oob_acc_q | row_oob;
            dy_d       = dy_q + DYW'(1);
            if (dy_q == DYW'(WIN - 1)) begin
               // Results are registered on the way into FINISH so they are
               // valid during the done cycle itself.
               state_d = StFinish;
               coll_d  = coll_acc_d;
               oob_d   = oob_acc_d;
               case (mode_q)
                  BlitOverlay: out_d = row_work;
                  BlitCommit:  out_d = (coll_acc_d | oob_acc_d) ? base_q : row_work;
                  default:     out_d = base_q;
               endcase
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         mode_q     <= BlitOverlay;
         np_q       <= 1'b0;
         piece_q    <= '0;
         px_q       <= '0;
         py_q       <= '0;
         dy_q       <= '0;
         work_q     <= '0;
         base_q     <= '0;
         out_q      <= '0;
         coll_acc_q <= 1'b0;
         oob_acc_q  <= 1'b0;
         coll_q     <= 1'b0;
         oob_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         np_q       <= np_d;
         piece_q    <= piece_d;
         px_q       <= px_d;
         py_q       <= py_d;
         dy_q       <= dy_d;
         work_q     <= work_d;
         base_q     <= base_d;
         out_q      <= out_d;
         coll_acc_q <= coll_acc_d;
         oob_acc_q  <= oob_acc_d;
         coll_q     <= coll_d;
         oob_q      <= oob_d;
      end
   end

   assign out_screen = out_q;
   assign collision  = coll_q;
   assign oob        = oob_q;
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StFinish);

endmodule
